// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the WF8 control sequencer: opcodes, FSM states,
// ALU mode / flag indices and the decoder intent bundle.
package alu_sequencer_pkg;

  localparam int unsigned DEF_BIT_COUNT  = 8;
  localparam int unsigned DEF_IMM_WIDTH  = 4;
  localparam int unsigned OPC_WIDTH      = 4;
  localparam int unsigned REG_IDX_WIDTH  = 3;

  localparam int unsigned ALU_MODE_ADD      = 0;
  localparam int unsigned ALU_MODE_SHIFT    = 1;
  localparam int unsigned ALU_MODE_NOT      = 2;
  localparam int unsigned ALU_MODE_AND      = 3;
  localparam int unsigned ALU_MODE_OR       = 4;
  localparam int unsigned ALU_MODE_BYPASS_A = 5;
  localparam int unsigned ALU_MODE_BYPASS_B = 6;
  localparam int unsigned ALU_MODE_COUNT    = 7;

  localparam int unsigned ALU_FLAG_ZERO  = 0;
  localparam int unsigned ALU_FLAG_COUNT = 4;

  localparam logic [REG_IDX_WIDTH-1:0] REG_RESERVED = REG_IDX_WIDTH'(7);

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SH   = 4'h3,
    OP_SHI  = 4'h4,
    OP_NOT  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_LI   = 4'hA,
    OP_BZ   = 4'hB,
    OP_J    = 4'hC,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_BRANCH = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef logic [ALU_MODE_COUNT-1:0] alu_mode_t;

  // Decoder intents; the FSM qualifies every enable with its state.
  typedef struct packed {
    alu_mode_t alu_mode;
    logic      b_sel;
    logic      rf_we;
    logic      acc_we;
    logic      is_bz;
    logic      is_j;
    logic      is_halt;
    logic      illegal;
  } dec_t;

  function automatic alu_mode_t alu_onehot(input int unsigned idx);
    return ALU_MODE_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_sequencer_insn_decoder.sv
// Purely combinational instruction decode: ir -> ALU mode, operand select,
// extended immediates and write-enable intents.
module alu_sequencer_insn_decoder
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned BIT_COUNT = DEF_BIT_COUNT,
  parameter int unsigned IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic [BIT_COUNT-1:0]     ir_i,
  output dec_t                     dec_o,
  output logic [BIT_COUNT-1:0]     imm_ext_o,
  output logic [BIT_COUNT-1:0]     imm_sext_o,
  output logic [REG_IDX_WIDTH-1:0] reg_idx_o
);

  localparam int unsigned EXT_WIDTH = BIT_COUNT - IMM_WIDTH;

  logic [OPC_WIDTH-1:0] opc;
  logic [IMM_WIDTH-1:0] imm;
  logic [BIT_COUNT-1:0] imm_zext;
  logic [BIT_COUNT-1:0] imm_sext;

  assign opc        = ir_i[BIT_COUNT-1 -: OPC_WIDTH];
  assign imm        = ir_i[IMM_WIDTH-1:0];
  assign imm_zext   = BIT_COUNT'(imm);
  assign imm_sext   = {{EXT_WIDTH{imm[IMM_WIDTH-1]}}, imm};
  assign imm_sext_o = imm_sext;
  assign reg_idx_o  = ir_i[REG_IDX_WIDTH-1:0];

  // Operand A is always the accumulator in EXEC; only b_sel varies.
  always_comb begin
    dec_o     = '0;
    imm_ext_o = '0;
    case (opc)
      OP_NOP: ;
      OP_ADD: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_ADD);
        dec_o.acc_we   = 1'b1;
      end
      OP_ADDI: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_ADD);
        dec_o.b_sel    = 1'b1;
        imm_ext_o      = imm_zext;
        dec_o.acc_we   = 1'b1;
      end
      OP_SH: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_SHIFT);
        dec_o.acc_we   = 1'b1;
      end
      OP_SHI: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_SHIFT);
        dec_o.b_sel    = 1'b1;
        imm_ext_o      = imm_sext;
        dec_o.acc_we   = 1'b1;
      end
      OP_NOT: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_NOT);
        dec_o.acc_we   = 1'b1;
      end
      OP_AND: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_AND);
        dec_o.acc_we   = 1'b1;
      end
      OP_OR: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_OR);
        dec_o.acc_we   = 1'b1;
      end
      OP_LD: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_B);
        dec_o.acc_we   = 1'b1;
      end
      OP_ST: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_A);
        // x7 is reserved: the store is dropped and flagged.
        if (reg_idx_o == REG_RESERVED) begin
          dec_o.illegal = 1'b1;
        end else begin
          dec_o.rf_we = 1'b1;
        end
      end
      OP_LI: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_B);
        dec_o.b_sel    = 1'b1;
        imm_ext_o      = imm_zext;
        dec_o.acc_we   = 1'b1;
      end
      OP_BZ: begin
        dec_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_A);
        dec_o.is_bz    = 1'b1;
      end
      OP_J:    dec_o.is_j    = 1'b1;
      OP_HALT: dec_o.is_halt = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// WF8 multi-cycle control FSM: fetch over a req/ack handshake, one EXEC
// cycle per instruction, and an extra BRANCH cycle for taken BZ / J.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned BIT_COUNT = DEF_BIT_COUNT,
  parameter int unsigned IMM_WIDTH = DEF_IMM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      imem_req,
  input  logic                      imem_ack,
  input  logic [BIT_COUNT-1:0]      imem_data,
  input  logic [ALU_FLAG_COUNT-1:0] alu_flags,
  output logic [ALU_MODE_COUNT-1:0] alu_mode,
  output logic                      alu_a_sel,
  output logic                      alu_b_sel,
  output logic [BIT_COUNT-1:0]      imm_ext,
  output logic [REG_IDX_WIDTH-1:0]  rf_raddr,
  output logic [REG_IDX_WIDTH-1:0]  rf_waddr,
  output logic                      rf_we,
  output logic                      acc_we,
  output logic                      pc_inc,
  output logic                      pc_we,
  output logic                      busy,
  output logic                      halted,
  output logic                      illegal
);

  state_e                     state_q, state_d;
  logic [BIT_COUNT-1:0]       ir_q, ir_d;
  dec_t                       dec;
  logic [BIT_COUNT-1:0]       dec_imm_ext;
  logic [BIT_COUNT-1:0]       dec_imm_sext;
  logic [REG_IDX_WIDTH-1:0]   dec_reg_idx;
  logic                       unused_flags;

  // Only the zero flag steers control flow.
  assign unused_flags = ^alu_flags;

  alu_sequencer_insn_decoder #(
    .BIT_COUNT (BIT_COUNT),
    .IMM_WIDTH (IMM_WIDTH)
  ) u_decoder (
    .ir_i       (ir_q),
    .dec_o      (dec),
    .imm_ext_o  (dec_imm_ext),
    .imm_sext_o (dec_imm_sext),
    .reg_idx_o  (dec_reg_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode from the registered state, so reset clears them at once.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    imem_req  = 1'b0;
    alu_mode  = '0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    imm_ext   = '0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_we     = 1'b0;
    acc_we    = 1'b0;
    pc_inc    = 1'b0;
    pc_we     = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        busy      = 1'b1;
        alu_mode  = dec.alu_mode;
        alu_b_sel = dec.b_sel;
        imm_ext   = dec_imm_ext;
        rf_raddr  = dec_reg_idx;
        rf_waddr  = dec_reg_idx;
        rf_we     = dec.rf_we;
        acc_we    = dec.acc_we;
        illegal   = dec.illegal;
        pc_inc    = 1'b1;
        state_d   = ST_FETCH;
        // PC is held on redirects so BRANCH adds to the branch's own address.
        if (dec.is_halt) begin
          pc_inc  = 1'b0;
          state_d = ST_HALT;
        end else if (dec.is_j || (dec.is_bz && alu_flags[ALU_FLAG_ZERO])) begin
          pc_inc  = 1'b0;
          state_d = ST_BRANCH;
        end
      end

      ST_BRANCH: begin
        busy      = 1'b1;
        alu_mode  = alu_onehot(ALU_MODE_ADD);
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        imm_ext   = dec_imm_sext;
        pc_we     = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + random scoreboard bench for alu_sequencer.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  typedef struct packed {
    logic [ALU_MODE_COUNT-1:0] alu_mode;
    logic       a_sel;
    logic       b_sel;
    logic [7:0] imm_ext;
    logic [2:0] rf_raddr;
    logic [2:0] rf_waddr;
    logic       rf_we;
    logic       acc_we;
    logic       pc_inc;
    logic       pc_we;
    logic       illegal;
    logic       busy;
    logic       halted;
    logic       imem_req;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [ALU_FLAG_COUNT-1:0] alu_flags = '0;
  logic imem_req;
  logic [ALU_MODE_COUNT-1:0] alu_mode;
  logic alu_a_sel, alu_b_sel;
  logic [7:0] imm_ext;
  logic [2:0] rf_raddr, rf_waddr;
  logic rf_we, acc_we, pc_inc, pc_we, busy, halted, illegal;

  int checks = 0;
  int errors = 0;
  out_t sb[$];

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_flags (alu_flags),
    .alu_mode  (alu_mode),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .imm_ext   (imm_ext),
    .rf_raddr  (rf_raddr),
    .rf_waddr  (rf_waddr),
    .rf_we     (rf_we),
    .acc_we    (acc_we),
    .pc_inc    (pc_inc),
    .pc_we     (pc_we),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [ALU_MODE_COUNT-1:0] oh(input int unsigned idx);
    logic [ALU_MODE_COUNT-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.alu_mode = alu_mode;   o.a_sel   = alu_a_sel; o.b_sel    = alu_b_sel;
    o.imm_ext  = imm_ext;    o.rf_raddr = rf_raddr; o.rf_waddr = rf_waddr;
    o.rf_we    = rf_we;      o.acc_we  = acc_we;    o.pc_inc   = pc_inc;
    o.pc_we    = pc_we;      o.illegal = illegal;   o.busy     = busy;
    o.halted   = halted;     o.imem_req = imem_req;
    return o;
  endfunction

  function automatic out_t fetch_vec();
    out_t e = '0;
    e.busy = 1'b1;
    e.imem_req = 1'b1;
    return e;
  endfunction

  function automatic out_t halt_vec();
    out_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  // Reference EXEC-cycle outputs for instruction byte d with zero flag z.
  function automatic out_t model_exec(input logic [7:0] d, input logic z);
    out_t e = '0;
    e.busy = 1'b1;
    e.pc_inc = 1'b1;
    e.rf_raddr = d[2:0];
    e.rf_waddr = d[2:0];
    case (d[7:4])
      4'h1: begin e.alu_mode = oh(ALU_MODE_ADD); e.acc_we = 1'b1; end
      4'h2: begin e.alu_mode = oh(ALU_MODE_ADD); e.b_sel = 1'b1;
                  e.imm_ext = {4'h0, d[3:0]}; e.acc_we = 1'b1; end
      4'h3: begin e.alu_mode = oh(ALU_MODE_SHIFT); e.acc_we = 1'b1; end
      4'h4: begin e.alu_mode = oh(ALU_MODE_SHIFT); e.b_sel = 1'b1;
                  e.imm_ext = {{4{d[3]}}, d[3:0]}; e.acc_we = 1'b1; end
      4'h5: begin e.alu_mode = oh(ALU_MODE_NOT); e.acc_we = 1'b1; end
      4'h6: begin e.alu_mode = oh(ALU_MODE_AND); e.acc_we = 1'b1; end
      4'h7: begin e.alu_mode = oh(ALU_MODE_OR); e.acc_we = 1'b1; end
      4'h8: begin e.alu_mode = oh(ALU_MODE_BYPASS_B); e.acc_we = 1'b1; end
      4'h9: begin
        e.alu_mode = oh(ALU_MODE_BYPASS_A);
        if (d[2:0] == 3'd7) e.illegal = 1'b1;
        else e.rf_we = 1'b1;
      end
      4'hA: begin e.alu_mode = oh(ALU_MODE_BYPASS_B); e.b_sel = 1'b1;
                  e.imm_ext = {4'h0, d[3:0]}; e.acc_we = 1'b1; end
      4'hB: begin e.alu_mode = oh(ALU_MODE_BYPASS_A); if (z) e.pc_inc = 1'b0; end
      4'hC, 4'hF: e.pc_inc = 1'b0;
      4'hD, 4'hE: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic out_t model_branch(input logic [7:0] d);
    out_t e = '0;
    e.busy = 1'b1;
    e.alu_mode = oh(ALU_MODE_ADD);
    e.a_sel = 1'b1;
    e.b_sel = 1'b1;
    e.imm_ext = {{4{d[3]}}, d[3:0]};
    e.pc_we = 1'b1;
    return e;
  endfunction

  task automatic compare(input string tag, input out_t o, input out_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One cycle: sample at negedge, check vector + invariants, return at posedge+1.
  task automatic sample(input out_t e, input string tag, output out_t o);
    logic inv_ok;
    @(negedge clk);
    o = observe();
    compare(tag, o, e);
    inv_ok = $onehot0(o.alu_mode) && !(o.rf_we && o.acc_we) && !(o.pc_inc && o.pc_we);
    checks++;
    assert (inv_ok === 1'b1) else begin
      errors++;
      $error("FAIL %s_invariant observed=%h expected=onehot0_and_exclusive", tag, o);
    end
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 in FETCH; leaves in FETCH (or HALT).
  task automatic do_fetch(input logic [7:0] d, input int unsigned waits, input logic z);
    out_t o, e;
    int unsigned reqs;
    int n;
    logic taken;
    reqs = 0;
    imem_data = d;
    alu_flags = ALU_FLAG_COUNT'($urandom);
    alu_flags[ALU_FLAG_ZERO] = z;
    imem_ack = 1'b0;
    for (int unsigned i = 0; i < waits; i++) begin
      sample(fetch_vec(), $sformatf("wait_%02h", d), o);
      reqs += 32'(o.imem_req);
    end
    imem_ack = 1'b1;
    sample(fetch_vec(), $sformatf("ack_%02h", d), o);
    reqs += 32'(o.imem_req);
    imem_ack = 1'b0;
    imem_data = 8'($urandom);
    checks++;
    assert (reqs === waits + 1) else begin
      errors++;
      $error("FAIL req_cycles_%02h observed=%0d expected=%0d", d, reqs, waits + 1);
    end
    taken = (d[7:4] == 4'hC) || ((d[7:4] == 4'hB) && z);
    sb.push_back(model_exec(d, z));
    if (taken) sb.push_back(model_branch(d));
    sb.push_back((d[7:4] == 4'hF) ? halt_vec() : fetch_vec());
    n = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      sample(e, $sformatf("op%02h_c%0d", d, n), o);
      n++;
    end
  endtask

  initial begin
    out_t o;
    logic [7:0] d;

    #2;
    compare("reset_state", observe(), '0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample('0, "idle", o);
    start = 1'b1;
    sample('0, "idle_start", o);
    start = 1'b0;

    do_fetch(8'h25, 3, 1'b0);   // ADDI 5 after three wait cycles
    do_fetch(8'hB8, 0, 1'b1);   // BZ -8 taken
    do_fetch(8'hB8, 1, 1'b0);   // BZ -8 not taken
    do_fetch(8'h97, 0, 1'b0);   // ST x7 reserved
    do_fetch(8'hD0, 2, 1'b0);   // illegal opcode
    do_fetch(8'h93, 0, 1'b1);   // ST x3
    do_fetch(8'h13, 0, 1'b0);   // ADD x3
    do_fetch(8'h4C, 0, 1'b0);   // SHI -4
    do_fetch(8'hA7, 0, 1'b1);   // LI 7
    do_fetch(8'hC7, 0, 1'b0);   // J +7
    do_fetch(8'h86, 1, 1'b0);   // LD x6

    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      if (d[7:4] == 4'hF) d[7:4] = 4'h0;
      do_fetch(d, $urandom_range(0, 2), 1'($urandom));
    end

    do_fetch(8'hF0, 0, 1'b0);   // HALT
    start = 1'b1;
    imem_ack = 1'b1;
    for (int k = 0; k < 10; k++) sample(halt_vec(), "halt_hold", o);
    start = 1'b0;
    imem_ack = 1'b0;

    rst_n = 1'b0;
    #1;
    compare("rst_from_halt", observe(), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    sample('0, "restart", o);
    start = 1'b0;
    sample(fetch_vec(), "fetch_pre_rst", o);

    // Async reset mid-cycle while requesting: req must drop without an edge.
    #2 rst_n = 1'b0;
    #1;
    compare("rst_async_drop", observe(), '0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample('0, "post_rst_idle0", o);
    sample('0, "post_rst_idle1", o);
    start = 1'b1;
    sample('0, "post_rst_start", o);
    start = 1'b0;
    do_fetch(8'h25, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM for the WF8 8-bit datapath.
- Fetches one instruction per handshake from instruction memory and decodes it.
- Drives the one-hot ALU mode vector, ALU operand selects and the immediate.
- Issues register-file, accumulator and PC write enables, and runs a second ALU pass for PC-relative branches.

Parameters:
- BIT_COUNT, 8: datapath and instruction width.
- IMM_WIDTH, 4: immediate field width, taken from ir[3:0].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- start  in  1  leave IDLE and begin fetching. Ignored outside IDLE.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle. Ignored while imem_req=0.
- imem_data  in  BIT_COUNT  instruction byte.
- alu_flags  in  ALU_FLAG_COUNT  ALU flags. Only ALU_FLAG_ZERO is used.
- alu_mode  out  ALU_MODE_COUNT  one-hot ALU mode, or all-zero.
- alu_a_sel  out  1  0 = accumulator, 1 = PC.
- alu_b_sel  out  1  0 = register file read data, 1 = imm_ext.
- imm_ext  out  BIT_COUNT  extended immediate.
- rf_raddr  out  3  register read index, ir[2:0].
- rf_waddr  out  3  register write index.
- rf_we  out  1  register write enable.
- acc_we  out  1  accumulator write enable (captures ALU c).
- pc_inc  out  1  PC <= PC+1.
- pc_we  out  1  PC <= ALU c.
- busy  out  1  high in FETCH, EXEC and BRANCH.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an illegal instruction.

Behaviour:
- Reset (async, any state): state=IDLE, ir=0, every output 0. imem_req drops immediately, including mid-fetch; an in-flight ack is lost.
- Instruction register ir: opcode = ir[7:4], operand = ir[3:0].
- States: IDLE, FETCH, EXEC, BRANCH, HALT.
- IDLE:
  - start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 is held until ack.
  - On imem_ack=1: ir <= imem_data and go to EXEC. imem_req is low from the next cycle.
  - Wait cycles are unbounded.
- EXEC (exactly 1 cycle): drive decode outputs combinationally from ir; write enables take effect at the closing edge. Default: pc_inc=1, then FETCH. Per opcode:
  - 0 NOP: alu_mode=0.
  - 1 ADD: ADD, a=acc, b=reg, acc_we.
  - 2 ADDI: ADD, a=acc, b=imm zero-extended, acc_we.
  - 3 SH: SHIFT, b=reg, acc_we.
  - 4 SHI: SHIFT, b=imm sign-extended, acc_we.
  - 5 NOT: NOT, acc_we.
  - 6 AND: AND, b=reg, acc_we.
  - 7 OR: OR, b=reg, acc_we.
  - 8 LD: BYPASS_B, b=reg, acc_we.
  - 9 ST: BYPASS_A, rf_we, rf_waddr=ir[2:0].
  - A LI: BYPASS_B, b=imm zero-extended, acc_we.
  - B BZ: BYPASS_A on acc. If alu_flags[ALU_FLAG_ZERO]=1: pc_inc=0 and go to BRANCH; else fall through as NOP.
  - C J: pc_inc=0, go to BRANCH.
  - F HALT: pc_inc=0, go to HALT.
  - D, E: NOP behaviour plus an illegal pulse.
- Register index rules:
  - Index 7 is reserved. ST to x7 suppresses rf_we and pulses illegal.
  - A read of x7 returns whatever the register file provides.
- BRANCH (1 cycle):
  - ADD, a_sel=PC, b_sel=imm, imm_ext = sign-extended ir[3:0], pc_we=1, then FETCH.
  - Target = address of the branch instruction + sext(imm), range -8..+7, 8-bit wrap-around.
- HALT: all outputs 0 except halted=1. Only reset exits.
- Outputs are zero outside EXEC/BRANCH: alu_mode, rf_we, acc_we, pc_inc, pc_we.
- Write-enable exclusivity: at most one of rf_we/acc_we, and at most one of pc_inc/pc_we, per cycle.
- Latency: fetch (1 + wait cycles) + 1 EXEC cycle, +1 cycle for a taken branch or J.

Decomposition:
- param.vh gains:
  - opcode defines OP_NOP..OP_HALT;
  - state encodings;
  - ALU_FLAG_ZERO index, using the existing ALU_MODE_* / ALU_FLAG_COUNT defines.
- One sub-module, insn_decoder: purely combinational ir -> alu_mode, selects, imm_ext and enable intents. The FSM gates its enables by state.

Test Plan:
- Reset, start pulse, imem_ack after 3 wait cycles with data 0x25 (ADDI 5) -> imem_req high 4 cycles; next cycle alu_mode=ADD, b_sel=1, imm_ext=0x05, acc_we=1, pc_inc=1.
- Data 0xB8 (BZ -8) with ZERO=1 -> EXEC has pc_inc=0; BRANCH has a_sel=1, imm_ext=0xF8, ADD, pc_we=1. Repeat with ZERO=0 -> pc_inc=1, no BRANCH state.
- Data 0x97 (ST x7) -> rf_we=0, illegal pulses once; data 0xD0 -> illegal pulses, acc_we=0, pc_inc=1.
- Data 0xF0 (HALT) -> halted=1, busy=0; further start/ack ignored for 10 cycles.
- rst_n low while imem_req=1 -> imem_req=0 the same cycle without a clock edge; after release, state IDLE and all outputs 0.
- Random opcode stream -> alu_mode is always one-hot or zero, and the write-enable exclusivity rules hold every cycle.
